hyperram_traffic_gen: RTL and testbench
=======================================

// Module: hyperram_traffic_gen
// PURPOSE
//  Parametrised traffic generator / checker driving NUM_CH hyperram_intf_impl_wrap controllers.
//  Adds over the single-pattern bring-up sequencer: per-channel select mask (broadcast),
//  selectable data patterns, per-channel read-back compare, error count and read timeout.
//  Sits between the debug VIO and the controller array.
// PARAMETERS
//  NUM_CH       4      number of HyperRAM controller channels
//  DATA_W       32     controller data-word width
//  CNT_W        32     word-counter and error-counter width
//  TIMEOUT_CYC  65535  READ cycles allowed with no valid beat before abort
// PORTS
//  clk                 in   1             single clock domain
//  rst                 in   1             asynchronous, active-high reset
//  start               in   1             toggle-type request: any level change = one request
//  ch_mask             in   NUM_CH        channels taking part in the request
//  mode                in   1             0 = write, 1 = read-and-compare
//  pattern_sel         in   2             data pattern, see BEHAVIOUR
//  seed                in   DATA_W        pattern seed
//  num_words           in   CNT_W         words per selected channel
//  ctrl_ready          in   NUM_CH        controller ready, per channel
//  ctrl_rd_data        in   NUM_CH*DATA_W read data; channel k at [k*DATA_W +: DATA_W]
//  ctrl_rd_data_valid  in   NUM_CH        read beat valid, per channel
//  ctrl_cs             out  NUM_CH        one-cycle launch pulse, per channel
//  ctrl_wr_data        out  DATA_W        write data, shared by all channels
//  ctrl_wr_data_valid  out  1             write beat valid
//  busy                out  1             high from LAUNCH through DONE
//  done                out  1             one-cycle pulse at end of request
//  err_count           out  CNT_W         saturating count of compare mismatches
//  timeout             out  1             last read request aborted by timeout
// BEHAVIOUR
//  Reset: state IDLE; every output 0; start_prev <= start.
//  start_prev follows start every cycle. A toggle is accepted only in IDLE with
//  (ctrl_ready & ch_mask) == ch_mask and ch_mask != 0. All other toggles are dropped, not queued.
//  States:
//   IDLE   -> LAUNCH on an accepted toggle. mask, mode, pattern_sel, seed and num_words are latched.
//   LAUNCH -> ctrl_cs = latched mask for exactly 1 cycle. err_count and timeout are cleared.
//             Next state is WRITE or READ per mode.
//             If num_words == 0: no cs pulse, go straight to DONE.
//   WRITE  -> One beat per cycle for num_words cycles. Beat i: wr_data_valid = 1, wr_data = P(i).
//             First beat is in the cycle after LAUNCH. Then DONE.
//   READ   -> Each selected channel k keeps its own index n_k.
//             A valid beat on k compares ctrl_rd_data[k] with P(n_k), then n_k++.
//             Valid beats on unselected channels are ignored.
//             Beats arriving after n_k == num_words are ignored.
//             Mismatches in the same cycle add their count; err_count saturates at all-ones.
//             Leave to DONE when n_k == num_words for every selected k.
//             Leave to DONE with timeout = 1 after TIMEOUT_CYC consecutive cycles with no
//             selected valid beat.
//   DONE   -> done = 1 for 1 cycle, then IDLE. err_count and timeout hold until the next LAUNCH.
//  Patterns P(i), with i in CNT_W bits and additions modulo 2^DATA_W:
//   0 constant: seed
//   1 increment: seed + i
//   2 rotate: seed rotated left by (i mod DATA_W)
//   3 inverted increment: ~(seed + i)
//  Inputs changing while busy have no effect. Reset mid-operation aborts at once; no done pulse.
// STRUCTURE
//  Package hyperram_tg_pkg: state encoding (IDLE, LAUNCH, WRITE, READ, DONE),
//  pattern codes PAT_CONST, PAT_INC, PAT_ROT, PAT_INV.
//  Sub-module hyperram_pattern_gen: combinational P(i) from (seed, index, sel).
//  One instance is used for write; NUM_CH instances are used for compare, via generate.
// TESTING
//  1. Write, mask 0001, num_words 4, pat 1, seed 0x10:
//     ctrl_cs = 0001 for 1 cycle, then wr_data 0x10..0x13 on 4 consecutive valid cycles,
//     then done pulse, err_count 0.
//  2. Read, mask 0001, num_words 4, pat 1; model returns 0x10..0x13 with gaps:
//     done pulse, err_count 0, timeout 0.
//  3. Read, mask 1111, pat 2, seed 0x1; channel 2 returns 0x5 in place of 0x4 at beat 2:
//     err_count 1. Done only after the slowest channel's 4th beat.
//  4. num_words 0 with any mode: no ctrl_cs, no wr_data_valid, done 2 cycles after the toggle.
//     Start toggle while busy, or with a selected ctrl_ready low: ignored, no second done.
//  5. Read, mask 0100, TIMEOUT_CYC 16, model silent: done and timeout = 1 after 16 idle cycles.
//     rst asserted mid-READ: all outputs 0 immediately, no done.

Source files
------------

// File: rtl/hyperram_tg_pkg.sv
// hyperram_tg_pkg: shared state encoding and pattern codes for the HyperRAM traffic generator.
// Revision 1.0
`default_nettype none

package hyperram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4
  } tg_state_e;

  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_INC   = 2'd1;
  localparam logic [1:0] PAT_ROT   = 2'd2;
  localparam logic [1:0] PAT_INV   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/hyperram_pattern_gen.sv
// hyperram_pattern_gen: combinational data pattern P(index) from seed and pattern select.
// Revision 1.0
`default_nettype none

module hyperram_pattern_gen
  import hyperram_tg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic [DATA_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  index_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int ROT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]   inc_val;
  logic [ROT_W-1:0]    rot_amt;
  logic [2*DATA_W-1:0] rot_dbl;

  assign inc_val = seed_i + DATA_W'(index_i);
  assign rot_amt = ROT_W'(index_i % CNT_W'(DATA_W));
  // Upper half of the doubled word shifted left is the left rotation.
  assign rot_dbl = {seed_i, seed_i} << rot_amt;

  always_comb begin
    data_o = seed_i;
    case (sel_i)
      PAT_CONST: data_o = seed_i;
      PAT_INC:   data_o = inc_val;
      PAT_ROT:   data_o = rot_dbl[2*DATA_W-1 -: DATA_W];
      PAT_INV:   data_o = ~inc_val;
      default:   data_o = seed_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hyperram_traffic_gen.sv
// hyperram_traffic_gen: multi-channel HyperRAM write / read-compare traffic generator.
// Revision 1.0
`default_nettype none

module hyperram_traffic_gen
  import hyperram_tg_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     mode,
  input  logic [1:0]               pattern_sel,
  input  logic [DATA_W-1:0]        seed,
  input  logic [CNT_W-1:0]         num_words,
  input  logic [NUM_CH-1:0]        ctrl_ready,
  input  logic [NUM_CH*DATA_W-1:0] ctrl_rd_data,
  input  logic [NUM_CH-1:0]        ctrl_rd_data_valid,
  output logic [NUM_CH-1:0]        ctrl_cs,
  output logic [DATA_W-1:0]        ctrl_wr_data,
  output logic                     ctrl_wr_data_valid,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         err_count,
  output logic                     timeout
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam int                SUM_W     = CNT_W + 1;

  tg_state_e          state_q, state_d;
  logic               start_prev_q;
  logic [NUM_CH-1:0]  mask_q;
  logic               mode_q;
  logic [1:0]         pat_q;
  logic [DATA_W-1:0]  seed_q;
  logic [CNT_W-1:0]   num_words_q;
  logic [CNT_W-1:0]   wr_idx_q;
  logic [CNT_W-1:0]   rd_idx_q [NUM_CH];
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [CNT_W-1:0]   err_count_q;
  logic               timeout_q;

  logic               accept;
  logic               wr_last;
  logic               any_sel_beat;
  logic               rd_all_done;
  logic               rd_timeout;
  logic [NUM_CH-1:0]  rd_take;
  logic [NUM_CH-1:0]  rd_mism;
  logic [NUM_CH-1:0]  ch_done;
  logic [DATA_W-1:0]  wr_pat;
  logic [SUM_W-1:0]   err_sum;

  assign accept = (state_q == ST_IDLE) && (start != start_prev_q) &&
                  (ch_mask != '0) && ((ctrl_ready & ch_mask) == ch_mask);
  assign wr_last      = (wr_idx_q + CNT_W'(1)) == num_words_q;
  assign any_sel_beat = |(mask_q & ctrl_rd_data_valid);
  assign rd_all_done  = &ch_done;
  assign rd_timeout   = !any_sel_beat && (idle_cnt_q == IDLE_LAST);

  hyperram_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_wr_pat (
    .seed_i  (seed_q),
    .index_i (wr_idx_q),
    .sel_i   (pat_q),
    .data_o  (wr_pat)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] exp_data;

    hyperram_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cmp_pat (
      .seed_i  (seed_q),
      .index_i (rd_idx_q[k]),
      .sel_i   (pat_q),
      .data_o  (exp_data)
    );

    // Beats past the requested word count are dropped, not compared.
    assign rd_take[k] = (state_q == ST_READ) && mask_q[k] && ctrl_rd_data_valid[k] &&
                        (rd_idx_q[k] != num_words_q);
    assign rd_mism[k] = rd_take[k] && (ctrl_rd_data[k*DATA_W +: DATA_W] != exp_data);
    assign ch_done[k] = !mask_q[k] || ((rd_idx_q[k] + CNT_W'(rd_take[k])) == num_words_q);
  end

  always_comb begin
    err_sum = {1'b0, err_count_q};
    for (int k = 0; k < NUM_CH; k++) begin
      err_sum = err_sum + SUM_W'(rd_mism[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (num_words_q == '0) state_d = ST_DONE;
        else if (mode_q)       state_d = ST_READ;
        else                   state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_last) state_d = ST_DONE;
      end
      ST_READ: begin
        if (rd_all_done || rd_timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_cs            = '0;
    ctrl_wr_data       = '0;
    ctrl_wr_data_valid = 1'b0;
    busy               = (state_q != ST_IDLE);
    done               = (state_q == ST_DONE);
    if (state_q == ST_LAUNCH && num_words_q != '0) ctrl_cs = mask_q;
    if (state_q == ST_WRITE) begin
      ctrl_wr_data_valid = 1'b1;
      ctrl_wr_data       = wr_pat;
    end
  end

  assign err_count = err_count_q;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= start;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      pat_q        <= '0;
      seed_q       <= '0;
      num_words_q  <= '0;
      wr_idx_q     <= '0;
      idle_cnt_q   <= '0;
      err_count_q  <= '0;
      timeout_q    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) rd_idx_q[k] <= '0;
    end else begin
      start_prev_q <= start;
      if (accept) begin
        mask_q      <= ch_mask;
        mode_q      <= mode;
        pat_q       <= pattern_sel;
        seed_q      <= seed;
        num_words_q <= num_words;
      end
      case (state_q)
        ST_LAUNCH: begin
          wr_idx_q    <= '0;
          idle_cnt_q  <= '0;
          err_count_q <= '0;
          timeout_q   <= 1'b0;
          for (int k = 0; k < NUM_CH; k++) rd_idx_q[k] <= '0;
        end
        ST_WRITE: wr_idx_q <= wr_idx_q + CNT_W'(1);
        ST_READ: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (rd_take[k]) rd_idx_q[k] <= rd_idx_q[k] + CNT_W'(1);
          end
          idle_cnt_q  <= any_sel_beat ? '0 : idle_cnt_q + IDLE_W'(1);
          err_count_q <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          if (rd_timeout && !rd_all_done) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hyperram_traffic_gen.sv
// tb_hyperram_traffic_gen: randomized bench for hyperram_traffic_gen with a behavioural model.
// Revision 1.0
`default_nettype none

module tb_hyperram_traffic_gen;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [NUM_CH-1:0]        ch_mask = '0;
  logic                     mode = 1'b0;
  logic [1:0]               pattern_sel = '0;
  logic [DATA_W-1:0]        seed = '0;
  logic [CNT_W-1:0]         num_words = '0;
  logic [NUM_CH-1:0]        ctrl_ready = '1;
  logic [NUM_CH*DATA_W-1:0] ctrl_rd_data = '0;
  logic [NUM_CH-1:0]        ctrl_rd_data_valid = '0;
  logic [NUM_CH-1:0]        ctrl_cs;
  logic [DATA_W-1:0]        ctrl_wr_data;
  logic                     ctrl_wr_data_valid;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         err_count;
  logic                     timeout;

  int n_checks = 0;
  int n_fail   = 0;

  hyperram_traffic_gen #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .mode(mode),
    .pattern_sel(pattern_sel), .seed(seed), .num_words(num_words),
    .ctrl_ready(ctrl_ready), .ctrl_rd_data(ctrl_rd_data),
    .ctrl_rd_data_valid(ctrl_rd_data_valid), .ctrl_cs(ctrl_cs),
    .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_data_valid(ctrl_wr_data_valid),
    .busy(busy), .done(done), .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input logic [1:0] sel, input logic [31:0] s,
                                            input logic [31:0] i);
    logic [63:0] dd;
    int          a;
    case (sel)
      2'd0: return s;
      2'd1: return s + i;
      2'd2: begin
        a  = int'(i % 32);
        dd = {s, s} >> (32 - a);
        return dd[31:0];
      end
      default: return ~(s + i);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it cycle by cycle; cycle 1 is the cycle after the toggle.
  task automatic run_req(input string name, input bit md, input logic [3:0] msk,
                         input logic [1:0] ps, input logic [31:0] sd, input int nw,
                         input int err_ch, input int err_beat, input logic [31:0] err_xor,
                         input bit silent, input bit poke_busy);
    int          sent [NUM_CH];
    int          wr_seen = 0, cs_seen = 0, cs_bad = 0, busy_bad = 0;
    int          done_cyc = -1, last_beat = 0, exp_err = 0, gap = 0, cyc = 0;
    int          extra = 0, exp_done;
    logic [31:0] err_at_done = '0, v;
    logic        to_at_done = 1'b0;
    bit          any;
    for (int k = 0; k < NUM_CH; k++) sent[k] = 0;
    mode = md; ch_mask = msk; pattern_sel = ps; seed = sd; num_words = nw; ctrl_ready = '1;
    start = ~start;
    while (cyc < 300 && done_cyc < 0) begin
      step();
      cyc++;
      if (cyc == 1) begin
        ch_mask = 4'($urandom); mode = 1'($urandom); pattern_sel = 2'($urandom);
        seed = $urandom; num_words = $urandom_range(1, 100);
      end
      if (poke_busy && cyc == 3) start = ~start;
      if (!busy) busy_bad++;
      if (ctrl_cs != '0) begin
        cs_seen++;
        if (cyc != 1 || ctrl_cs != msk) cs_bad++;
      end
      if (ctrl_wr_data_valid) begin
        check({name, "_wr_data"}, ctrl_wr_data, model_pat(ps, sd, wr_seen));
        wr_seen++;
      end
      if (done) begin
        done_cyc    = cyc;
        err_at_done = err_count;
        to_at_done  = timeout;
      end else begin
        ctrl_rd_data_valid = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (md && cyc >= 2 && msk[k] && sent[k] < nw && !silent &&
              ($urandom_range(0, 2) != 0 || gap >= 8)) begin
            v = model_pat(ps, sd, sent[k]);
            if (k == err_ch && sent[k] == err_beat && err_xor != 0) begin
              v = v ^ err_xor;
              exp_err++;
            end
            ctrl_rd_data[k*32 +: 32] = v;
            ctrl_rd_data_valid[k]    = 1'b1;
            sent[k]++;
            last_beat = cyc;
            any = 1'b1;
          end else if ((!msk[k] || sent[k] >= nw) && $urandom_range(0, 3) == 0) begin
            ctrl_rd_data[k*32 +: 32] = $urandom;
            ctrl_rd_data_valid[k]    = 1'b1;
          end
        end
        gap = any ? 0 : gap + 1;
      end
    end
    ctrl_rd_data_valid = '0;
    if (nw == 0)             exp_done = 2;
    else if (!md)            exp_done = nw + 2;
    else if (silent)         exp_done = TIMEOUT_CYC + 2;
    else                     exp_done = last_beat + 1;
    check({name, "_done_cyc"}, done_cyc, exp_done);
    check({name, "_cs_pulses"}, cs_seen, (nw > 0) ? 1 : 0);
    check({name, "_cs_value"}, cs_bad, 0);
    check({name, "_wr_beats"}, wr_seen, md ? 0 : nw);
    check({name, "_busy"}, busy_bad, 0);
    check({name, "_err_count"}, err_at_done, exp_err);
    check({name, "_timeout"}, to_at_done, (md && silent && nw > 0) ? 1 : 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) extra++;
    end
    check({name, "_no_extra_done"}, extra, 0);
    check({name, "_err_hold"}, err_count, exp_err);
  endtask

  task automatic expect_ignored(input string name);
    int seen = 0;
    start = ~start;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy || done || ctrl_cs != '0) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int seen;
    step();
    step();
    check("reset_outputs", {ctrl_cs, ctrl_wr_data, ctrl_wr_data_valid, busy, done, err_count, timeout}, 0);
    rst = 1'b0;
    step();

    run_req("t1_write", 1'b0, 4'b0001, 2'd1, 32'h10, 4, -1, 0, 0, 1'b0, 1'b0);
    run_req("t2_read", 1'b1, 4'b0001, 2'd1, 32'h10, 4, -1, 0, 0, 1'b0, 1'b0);
    run_req("t3_read_err", 1'b1, 4'b1111, 2'd2, 32'h1, 4, 2, 2, 32'h1, 1'b0, 1'b0);
    run_req("t4_zero_wr", 1'b0, 4'b0011, 2'd0, 32'hA5, 0, -1, 0, 0, 1'b0, 1'b0);
    run_req("t4_zero_rd", 1'b1, 4'b1000, 2'd3, 32'hA5, 0, -1, 0, 0, 1'b0, 1'b0);
    run_req("t4_busy_toggle", 1'b0, 4'b0110, 2'd3, 32'h1234, 6, -1, 0, 0, 1'b0, 1'b1);

    ch_mask = 4'b0101; ctrl_ready = 4'b0001;
    expect_ignored("t4_ready_low_ignored");
    ch_mask = 4'b0000; ctrl_ready = 4'b1111;
    expect_ignored("t4_zero_mask_ignored");

    run_req("t5_timeout", 1'b1, 4'b0100, 2'd1, 32'h0, 4, -1, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      bit md;
      md = 1'($urandom);
      run_req($sformatf("rnd%0d", r), md, 4'($urandom_range(1, 15)), 2'($urandom), $urandom,
              $urandom_range(0, 10), md ? $urandom_range(0, 3) : -1, $urandom_range(0, 9),
              ($urandom_range(0, 1) != 0) ? $urandom : 32'h0,
              md && ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    mode = 1'b1; ch_mask = 4'b0100; num_words = 4; ctrl_ready = '1;
    start = ~start;
    for (int i = 0; i < 5; i++) step();
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_read_outputs",
          {ctrl_cs, ctrl_wr_data, ctrl_wr_data_valid, busy, done, err_count, timeout}, 0);
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) seen++;
    end
    check("rst_no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
